// File: rtl/idu_pipe_stage.sv
// Decode-to-execute pipeline register with valid/ready flow control, flush and a stall counter.
// Latency: 1 cycle from in_fire to out_valid. Backpressure: in_ready follows out_ready
// combinationally, or with IDU_PIPE_SKID_BUF_EN defined it is a flop backed by a one-entry skid.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           drop stage contents and same-cycle input
//   in_valid/in_ready/in_data/in_ctrl      upstream (IFU) handshake and payloads
//   out_valid/out_ready/out_data/out_ctrl  downstream (EXU) handshake and payloads
//   stall_cnt                       saturating count of cycles with out_valid & ~out_ready
//
// Optional feature macro: IDU_PIPE_SKID_BUF_EN (skid entry, registered in_ready).
// Datapath payload is only written on a load and is never cleared except by reset.
// Control payload is cleared in the registers whenever the entry holding it empties,
// so out_ctrl is 0 in every cycle with out_valid = 0.
module idu_pipe_stage #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Stall counter: counts EXU back-pressure cycles, sticks at all-ones, ignores flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef IDU_PIPE_SKID_BUF_EN

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    occ_e              state_q;
    occ_e              state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    logic ld_main_in;
    logic ld_main_skid;
    logic clr_main;
    logic ld_skid;
    logic clr_skid;

    // in_ready has no path from out_ready; flush forces it high so the
    // redirect-cycle word is always swallowed even when the skid is full.
    assign in_ready  = in_ready_q | flush;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        clr_main     = 1'b0;
        ld_skid      = 1'b0;
        clr_skid     = 1'b0;
        if (flush) begin
            state_d  = S_EMPTY;
            clr_main = 1'b1;
            clr_skid = 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d    = S_ONE;
                        ld_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_fire && !out_fire) begin
                        // EXU stalled: park the new word behind the main entry.
                        state_d = S_TWO;
                        ld_skid = 1'b1;
                    end else if (in_fire) begin
                        ld_main_in = 1'b1;
                    end else if (out_fire) begin
                        state_d  = S_EMPTY;
                        clr_main = 1'b1;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_d      = S_ONE;
                        ld_main_skid = 1'b1;
                        clr_skid     = 1'b1;
                    end
                end
                default: begin
                    state_d  = S_EMPTY;
                    clr_main = 1'b1;
                    clr_skid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);

            if (ld_main_in) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (ld_main_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end else if (clr_main) begin
                main_ctrl_q <= '0;
            end

            if (ld_skid) begin
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end else if (clr_skid) begin
                skid_ctrl_q <= '0;
            end
        end
    end

`else

    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Accept when empty, when the current word leaves this cycle, or during flush.
    assign in_ready  = flush | ~vld_q | out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            ctrl_q <= '0;
        end else if (flush) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else if (in_fire) begin
            // Covers simultaneous out_fire: the new word replaces the departing one.
            vld_q  <= 1'b1;
            data_q <= in_data;
            ctrl_q <= in_ctrl;
        end else if (out_fire) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end
    end

`endif

endmodule
